// File: rtl/rf_port_sequencer_if.sv
// Request-side bundle for rf_port_sequencer.
// Carries the clocked read request/response channel and the write request channel.
//   master : requester (drives requests, receives ready/response)
//   slave  : rf_port_sequencer
interface rf_port_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
) ();
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_req_valid, rd_addr1, rd_addr2, wr_valid, wr_addr, wr_data,
        input  rd_req_ready, rd_resp_valid, rd_data1, rd_data2, wr_ready
    );

    modport slave (
        input  rd_req_valid, rd_addr1, rd_addr2, wr_valid, wr_addr, wr_data,
        output rd_req_ready, rd_resp_valid, rd_data1, rd_data2, wr_ready
    );
endinterface

// File: rtl/rf_port_sequencer.sv
// Sequencer in front of a single-select register file (select 1 = read, 0 = write).
// The file's write path is level-sensitive, so every rf_* output comes straight from a flop
// and a write is framed as setup / one-cycle select-low pulse / hold.
// Writes are buffered in a small FIFO; reads that hit a queued write wait for it to drain.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req (slave)       : read request/response and write request channels
//   rf_select         : 1 = read, 0 = write (low only for one cycle per write)
//   rf_read_addr1/2   : read addresses to the register file
//   rf_write_addr/data: write address/data to the register file
//   rf_read_data1/2   : read data from the register file
module rf_port_sequencer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned WQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_port_sequencer_if.slave req,
    output logic              rf_select,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2
);
    localparam int unsigned PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        StIdle, StRdAddr, StRdCap, StWrSetup, StWrPulse, StWrHold
    } state_e;

    state_e            state;
    logic [ADDR_W-1:0] wq_addr [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data [WQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              enq, deq, hazard, rd_accept, wr_ready_int;
    logic              rd_resp_valid_q;
    logic [DATA_W-1:0] rd_data1_q, rd_data2_q;

    assign wr_ready_int = (count != CNT_W'(WQ_DEPTH));
    assign enq          = req.wr_valid && wr_ready_int;
    // Head entry stays in the queue (and visible to the hazard check) until the write completes.
    assign deq          = (state == StWrHold);
    assign rd_accept    = req.rd_req_valid && req.rd_req_ready;

    assign req.wr_ready      = wr_ready_int;
    assign req.rd_req_ready  = (state == StIdle) && !hazard;
    assign req.rd_resp_valid = rd_resp_valid_q;
    assign req.rd_data1      = rd_data1_q;
    assign req.rd_data2      = rd_data2_q;

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(WQ_DEPTH); i++) begin
            if ((CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count) &&
                (wq_addr[i] == req.rd_addr1 || wq_addr[i] == req.rd_addr2)) begin
                hazard = 1'b1;
            end
        end
        if (enq && (req.wr_addr == req.rd_addr1 || req.wr_addr == req.rd_addr2)) begin
            hazard = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            wq_addr[wr_ptr] <= req.wr_addr;
            wq_data[wr_ptr] <= req.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq && !deq)      count <= count + CNT_W'(1);
            else if (!enq && deq) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StIdle;
            rf_select       <= 1'b1;
            rf_read_addr1   <= '0;
            rf_read_addr2   <= '0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            rd_resp_valid_q <= 1'b0;
            rd_data1_q      <= '0;
            rd_data2_q      <= '0;
        end else begin
            rd_resp_valid_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (rd_accept) begin
                        rf_read_addr1 <= req.rd_addr1;
                        rf_read_addr2 <= req.rd_addr2;
                        state         <= StRdAddr;
                    end else if (count != '0) begin
                        rf_write_addr <= wq_addr[rd_ptr];
                        rf_write_data <= wq_data[rd_ptr];
                        state         <= StWrSetup;
                    end
                end
                // Addresses have been on the file for a full cycle; capture on the way out so
                // the response is visible two cycles after acceptance.
                StRdAddr: begin
                    rd_data1_q      <= rf_read_data1;
                    rd_data2_q      <= rf_read_data2;
                    rd_resp_valid_q <= 1'b1;
                    state           <= StRdCap;
                end
                StRdCap:   state <= StIdle;
                StWrSetup: begin
                    rf_select <= 1'b0;
                    state     <= StWrPulse;
                end
                StWrPulse: begin
                    rf_select <= 1'b1;
                    state     <= StWrHold;
                end
                StWrHold:  state <= StIdle;
                default:   state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_port_sequencer.sv
// Directed bench for rf_port_sequencer with a behavioural level-sensitive register file.
module tb_rf_port_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rf_select;
    logic [4:0]  rf_read_addr1, rf_read_addr2, rf_write_addr;
    logic [15:0] rf_write_data, rf_read_data1, rf_read_data2;
    logic [15:0] mem [32];
    int          vectors = 0;
    int          miscompares = 0;
    int          low_cnt = 0;
    int          low_base;

    rf_port_sequencer_if #(.DATA_W(16), .ADDR_W(5)) vi ();

    rf_port_sequencer #(.DATA_W(16), .ADDR_W(5), .WQ_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (vi),
        .rf_select     (rf_select),
        .rf_read_addr1 (rf_read_addr1),
        .rf_read_addr2 (rf_read_addr2),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2)
    );

    always #5 clk = ~clk;

    // Register file: writes when select falls (addr/data are already stable), reads combinational.
    initial for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    always @(negedge rf_select) mem[rf_write_addr] = rf_write_data;
    assign rf_read_data1 = mem[rf_read_addr1];
    assign rf_read_data2 = mem[rf_read_addr2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write stability: around every select-low sample, addr/data match the neighbours.
    logic        h1_sel = 1'b1, h2_sel = 1'b1, h1_rst = 1'b0, h2_rst = 1'b0;
    logic [4:0]  h1_addr = '0, h2_addr = '0;
    logic [15:0] h1_data = '0, h2_data = '0;
    always @(negedge clk) begin
        low_cnt <= low_cnt + (rf_select ? 0 : 1);
        if (h1_sel == 1'b0 && h1_rst && h2_rst && rst_n) begin
            check("stab_addr_prev", {27'd0, h2_addr}, {27'd0, h1_addr});
            check("stab_addr_next", {27'd0, rf_write_addr}, {27'd0, h1_addr});
            check("stab_data_prev", {16'd0, h2_data}, {16'd0, h1_data});
            check("stab_data_next", {16'd0, rf_write_data}, {16'd0, h1_data});
        end
        h2_sel <= h1_sel; h2_rst <= h1_rst; h2_addr <= h1_addr; h2_data <= h1_data;
        h1_sel <= rf_select; h1_rst <= rst_n; h1_addr <= rf_write_addr; h1_data <= rf_write_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [15:0] d);
        int n = 0;
        vi.wr_valid = 1'b1; vi.wr_addr = a; vi.wr_data = d;
        #1;
        while (!vi.wr_ready && n < 64) begin
            tick(); n++;
        end
        check("wr_accept", {31'd0, vi.wr_ready}, 32'd1);
        @(posedge clk); #1;
        vi.wr_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [15:0] e1, input logic [15:0] e2);
        int n = 0;
        vi.rd_req_valid = 1'b1; vi.rd_addr1 = a1; vi.rd_addr2 = a2;
        #1;
        while (!vi.rd_req_ready && n < 64) begin
            tick(); n++;
        end
        check({tag, "_accept"}, {31'd0, vi.rd_req_ready}, 32'd1);
        @(posedge clk); #1;
        vi.rd_req_valid = 1'b0;
        check({tag, "_lat1"}, {31'd0, vi.rd_resp_valid}, 32'd0);
        tick();
        check({tag, "_lat2"}, {31'd0, vi.rd_resp_valid}, 32'd1);
        check({tag, "_d1"}, {16'd0, vi.rd_data1}, {16'd0, e1});
        check({tag, "_d2"}, {16'd0, vi.rd_data2}, {16'd0, e2});
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vi.rd_req_valid = 1'b0; vi.rd_addr1 = '0; vi.rd_addr2 = '0;
        vi.wr_valid = 1'b0; vi.wr_addr = '0; vi.wr_data = '0;

        // Reset with random inputs.
        for (int i = 0; i < 4; i++) begin
            vi.rd_req_valid = 1'($urandom); vi.rd_addr1 = 5'($urandom);
            vi.rd_addr2 = 5'($urandom); vi.wr_valid = 1'($urandom);
            vi.wr_addr = 5'($urandom); vi.wr_data = 16'($urandom);
            tick();
        end
        check("rst_select", {31'd0, rf_select}, 32'd1);
        check("rst_resp_valid", {31'd0, vi.rd_resp_valid}, 32'd0);
        check("rst_wr_ready", {31'd0, vi.wr_ready}, 32'd1);
        check("rst_rd_data1", {16'd0, vi.rd_data1}, 32'd0);
        check("rst_wr_addr", {27'd0, rf_write_addr}, 32'd0);
        check("rst_rd_addr1", {27'd0, rf_read_addr1}, 32'd0);
        vi.rd_req_valid = 1'b0; vi.wr_valid = 1'b0;
        vi.rd_addr1 = '0; vi.rd_addr2 = '0; vi.wr_addr = '0; vi.wr_data = '0;
        rst_n = 1'b1;
        tick();

        // Single write r5 = BEEF, then read it back.
        low_base = low_cnt;
        vi.wr_valid = 1'b1; vi.wr_addr = 5'd5; vi.wr_data = 16'hBEEF;
        #1 check("w1_ready", {31'd0, vi.wr_ready}, 32'd1);
        tick();
        vi.wr_valid = 1'b0;
        tick();
        check("w1_setup_sel", {31'd0, rf_select}, 32'd1);
        check("w1_setup_addr", {27'd0, rf_write_addr}, 32'd5);
        check("w1_setup_data", {16'd0, rf_write_data}, 32'hBEEF);
        tick();
        check("w1_pulse_sel", {31'd0, rf_select}, 32'd0);
        tick();
        check("w1_hold_sel", {31'd0, rf_select}, 32'd1);
        tick();
        do_read("r5", 5'd5, 5'd0, 16'hBEEF, 16'h0000);
        check("w1_low_cycles", 32'(low_cnt - low_base), 32'd1);
        check("r5_hold_data", {16'd0, vi.rd_data1}, 32'hBEEF);

        // RAW hazard: write r7 and read r7 in the same cycle.
        vi.wr_valid = 1'b1; vi.wr_addr = 5'd7; vi.wr_data = 16'h1234;
        vi.rd_req_valid = 1'b1; vi.rd_addr1 = 5'd7; vi.rd_addr2 = 5'd5;
        #1 check("raw_ready_enq", {31'd0, vi.rd_req_ready}, 32'd0);
        tick();
        vi.wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("raw_ready_drain", {31'd0, vi.rd_req_ready}, 32'd0);
            tick();
        end
        do_read("raw", 5'd7, 5'd5, 16'h1234, 16'hBEEF);

        // Queue full: five back-to-back writes r1..r5 = 1..5.
        for (int i = 1; i <= 4; i++) begin
            vi.wr_valid = 1'b1; vi.wr_addr = 5'(i); vi.wr_data = 16'(i);
            #1 check("qf_ready", {31'd0, vi.wr_ready}, 32'd1);
            tick();
        end
        vi.wr_addr = 5'd5; vi.wr_data = 16'd5;
        #1 check("qf_full", {31'd0, vi.wr_ready}, 32'd0);
        do_write(5'd5, 16'd5);
        do_read("qf12", 5'd1, 5'd2, 16'd1, 16'd2);
        do_read("qf34", 5'd3, 5'd4, 16'd3, 16'd4);
        do_read("qf5", 5'd5, 5'd7, 16'd5, 16'h1234);

        // Read priority over a pending write.
        vi.wr_valid = 1'b1; vi.wr_addr = 5'd9; vi.wr_data = 16'h0099;
        #1 check("pri_wr_ready", {31'd0, vi.wr_ready}, 32'd1);
        tick();
        vi.wr_valid = 1'b0;
        vi.rd_req_valid = 1'b1; vi.rd_addr1 = 5'd3; vi.rd_addr2 = 5'd4;
        #1 check("pri_rd_ready", {31'd0, vi.rd_req_ready}, 32'd1);
        tick();
        vi.rd_req_valid = 1'b0;
        check("pri_lat1", {31'd0, vi.rd_resp_valid}, 32'd0);
        check("pri_no_wr_yet", {27'd0, rf_write_addr}, 32'd5);
        tick();
        check("pri_lat2", {31'd0, vi.rd_resp_valid}, 32'd1);
        check("pri_old_r3", {16'd0, vi.rd_data1}, 32'd3);
        check("pri_old_r4", {16'd0, vi.rd_data2}, 32'd4);
        tick();
        tick();
        check("pri_wr_setup", {27'd0, rf_write_addr}, 32'd9);
        check("pri_wr_data", {16'd0, rf_write_data}, 32'h0099);
        do_read("pri_r9", 5'd9, 5'd3, 16'h0099, 16'd3);

        // Reset during WR_PULSE.
        vi.wr_valid = 1'b1; vi.wr_addr = 5'd10; vi.wr_data = 16'hAAAA;
        tick();
        vi.wr_addr = 5'd11; vi.wr_data = 16'hBBBB;
        tick();
        vi.wr_valid = 1'b0;
        check("mr_setup_addr", {27'd0, rf_write_addr}, 32'd10);
        tick();
        check("mr_pulse_sel", {31'd0, rf_select}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check("mr_async_sel", {31'd0, rf_select}, 32'd1);
        check("mr_wr_ready", {31'd0, vi.wr_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_idle_sel", {31'd0, rf_select}, 32'd1);
            check("mr_no_drain", {27'd0, rf_write_addr}, 32'd0);
        end
        do_read("mr_r11", 5'd11, 5'd0, 16'h0000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
